// File: rtl/flash_sweep_seq.sv
// flash_sweep_seq: drives the flasher width/level/rate inputs,
// either manual passthrough or a PPS-paced level x width sweep.
module flash_sweep_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_pps,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] man_width,
  input  logic [4:0] man_level,
  input  logic [2:0] man_rate,
  input  logic [4:0] lvl_start,
  input  logic [4:0] lvl_stop,
  input  logic [4:0] lvl_step,
  input  logic [3:0] wid_start,
  input  logic [3:0] wid_stop,
  input  logic [7:0] dwell,
  input  logic [2:0] sweep_rate,
  output logic [3:0] width,
  output logic [4:0] level,
  output logic [2:0] rate,
  output logic       busy,
  output logic       done,
  output logic [9:0] point_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_DWELL,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync3_q, sync3_d;
  logic [3:0] width_q, width_d;
  logic [4:0] level_q, level_d;
  logic [2:0] rate_q, rate_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [9:0] pidx_q, pidx_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [4:0] lstart_q, lstart_d;
  logic [4:0] lstop_q, lstop_d;
  logic [4:0] lstep_q, lstep_d;
  logic [3:0] wstop_q, wstop_d;
  logic [7:0] dwell_q, dwell_d;

  logic       pps_tick;
  logic [5:0] nxt_lvl;
  logic [7:0] cnt_inc;

  // PPS synchronizer chain plus edge-detect history flop
  always_comb begin
    sync1_d = one_pps;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign pps_tick = sync2_q & ~sync3_q;

  // Sweep sequencer: next state, outputs and latched config
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    level_d  = level_q;
    rate_d   = rate_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pidx_d   = pidx_q;
    dcnt_d   = dcnt_q;
    lstart_d = lstart_q;
    lstop_d  = lstop_q;
    lstep_d  = lstep_q;
    wstop_d  = wstop_q;
    dwell_d  = dwell_q;
    nxt_lvl  = {1'b0, level_q} + {1'b0, lstep_q};
    cnt_inc  = dcnt_q + 8'd1;
    unique case (state_q)
      S_IDLE: begin
        width_d = man_width;
        level_d = man_level;
        rate_d  = man_rate;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = S_ARM;
          lstart_d = lvl_start;
          lstep_d  = (lvl_step == 5'd0) ? 5'd1 : lvl_step;
          lstop_d  = (lvl_stop < lvl_start) ? lvl_start : lvl_stop;
          wstop_d  = (wid_stop < wid_start) ? wid_start : wid_stop;
          dwell_d  = (dwell == 8'd0) ? 8'd1 : dwell;
          width_d  = wid_start;
          level_d  = lvl_start;
          rate_d   = sweep_rate;
          pidx_d   = 10'd0;
          busy_d   = 1'b1;
          dcnt_d   = 8'd0;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (pps_tick) begin
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (pps_tick) begin
          if (cnt_inc == dwell_q) begin
            dcnt_d = 8'd0;
            if (nxt_lvl <= {1'b0, lstop_q}) begin
              level_d = nxt_lvl[4:0];
              pidx_d  = pidx_q + 10'd1;
            end else if (width_q < wstop_q) begin
              level_d = lstart_q;
              width_d = width_q + 4'd1;
              pidx_d  = pidx_q + 10'd1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            dcnt_d = cnt_inc;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, output and config registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      width_q  <= 4'd0;
      level_q  <= 5'd0;
      rate_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pidx_q   <= 10'd0;
      dcnt_q   <= 8'd0;
      lstart_q <= 5'd0;
      lstop_q  <= 5'd0;
      lstep_q  <= 5'd1;
      wstop_q  <= 4'd0;
      dwell_q  <= 8'd1;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      width_q  <= width_d;
      level_q  <= level_d;
      rate_q   <= rate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pidx_q   <= pidx_d;
      dcnt_q   <= dcnt_d;
      lstart_q <= lstart_d;
      lstop_q  <= lstop_d;
      lstep_q  <= lstep_d;
      wstop_q  <= wstop_d;
      dwell_q  <= dwell_d;
    end
  end

  assign width     = width_q;
  assign level     = level_q;
  assign rate      = rate_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign point_idx = pidx_q;

endmodule

// File: tb/tb_flash_sweep_seq.sv
// tb_flash_sweep_seq: directed scoreboard bench for flash_sweep_seq.
// Expected outputs are queued with each stimulus and popped on output.
module tb_flash_sweep_seq;

  logic       clk = 1'b0;
  logic       rst, one_pps, start, abort;
  logic [3:0] man_width, wid_start, wid_stop, width;
  logic [4:0] man_level, lvl_start, lvl_stop, lvl_step, level;
  logic [2:0] man_rate, sweep_rate, rate;
  logic [7:0] dwell;
  logic       busy, done;
  logic [9:0] point_idx;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] w;
    logic [4:0] l;
    logic [2:0] r;
    logic       b;
    logic       d;
    logic [9:0] p;
  } exp_t;

  exp_t sb[$];
  int   pw[$];
  int   pl[$];

  always #5 clk = ~clk;

  flash_sweep_seq dut (
    .clk(clk), .rst(rst), .one_pps(one_pps),
    .start(start), .abort(abort),
    .man_width(man_width), .man_level(man_level),
    .man_rate(man_rate),
    .lvl_start(lvl_start), .lvl_stop(lvl_stop),
    .lvl_step(lvl_step),
    .wid_start(wid_start), .wid_stop(wid_stop),
    .dwell(dwell), .sweep_rate(sweep_rate),
    .width(width), .level(level), .rate(rate),
    .busy(busy), .done(done), .point_idx(point_idx)
  );

  always @(posedge clk)
    if (!rst && done) done_cnt <= done_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input int w, input int l,
                      input int r, input int b, input int d,
                      input int p);
    exp_t e;
    e.tag = tag;
    e.w = 4'(w);
    e.l = 5'(l);
    e.r = 3'(r);
    e.b = 1'(b);
    e.d = 1'(d);
    e.p = 10'(p);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL sb_empty: got no expected entry, required one");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert ({width, level, rate, busy, done, point_idx} ===
              {e.w, e.l, e.r, e.b, e.d, e.p}) else begin
        miscompares++;
        $error("FAIL %s: got w=%0d l=%0d r=%0d busy=%b done=%b idx=%0d, required w=%0d l=%0d r=%0d busy=%b done=%b idx=%0d",
               e.tag, width, level, rate, busy, done, point_idx,
               e.w, e.l, e.r, e.b, e.d, e.p);
      end
    end
  endtask

  task automatic check_int(input string tag, input int got,
                           input int req);
    vectors++;
    assert (got === req) else begin
      miscompares++;
      $error("FAIL %s: got %0d, required %0d", tag, got, req);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pps_rise();
    one_pps = 1'b1;
    cyc(3);
  endtask

  task automatic pps_fall();
    one_pps = 1'b0;
    cyc(4);
  endtask

  task automatic pps_hold(input string tag, input int w, input int l,
                          input int r, input int p);
    push(tag, w, l, r, 1, 0, p);
    pps_rise();
    check_out();
    pps_fall();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    one_pps = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    man_width = 4'd5;
    man_level = 5'd12;
    man_rate = 3'd3;
    lvl_start = 5'd0;
    lvl_stop = 5'd0;
    lvl_step = 5'd0;
    wid_start = 4'd0;
    wid_stop = 4'd0;
    dwell = 8'd0;
    sweep_rate = 3'd0;
    cyc(3);

    rst = 1'b0;
    push("reset_state", 0, 0, 0, 0, 0, 0);
    check_out();
    push("manual", 5, 12, 3, 0, 0, 0);
    cyc(1);
    check_out();

    lvl_start = 5'd4;
    lvl_stop = 5'd10;
    lvl_step = 5'd3;
    wid_start = 4'd2;
    wid_stop = 4'd3;
    dwell = 8'd2;
    sweep_rate = 3'd5;
    for (int w = 2; w <= 3; w++)
      for (int l = 4; l <= 10; l += 3) begin
        pw.push_back(w);
        pl.push_back(l);
      end
    push("sw_arm", 2, 4, 5, 1, 0, 0);
    do_start();
    check_out();
    pps_hold("sw_sync", 2, 4, 5, 0);
    for (int k = 0; k < pw.size(); k++) begin
      pps_hold("sw_hold", pw[k], pl[k], 5, k);
      if (k == 2) begin
        lvl_stop = 5'd5;
        sweep_rate = 3'd6;
        push("sw_restart", pw[k], pl[k], 5, 1, 0, k);
        do_start();
        check_out();
      end
      if (k + 1 < pw.size()) begin
        pps_hold("sw_adv", pw[k+1], pl[k+1], 5, k + 1);
      end else begin
        push("sw_done", pw[k], pl[k], 5, 1, 1, k);
        pps_rise();
        check_out();
        push("sw_busy_drop", pw[k], pl[k], 5, 0, 0, k);
        cyc(1);
        check_out();
        push("sw_man", 5, 12, 3, 0, 0, k);
        cyc(1);
        check_out();
        pps_fall();
      end
    end
    check_int("sw_done_count", done_cnt, 1);

    lvl_start = 5'd30;
    lvl_stop = 5'd31;
    lvl_step = 5'd31;
    wid_start = 4'd0;
    wid_stop = 4'd0;
    dwell = 8'd0;
    sweep_rate = 3'd2;
    push("ov_arm", 0, 30, 2, 1, 0, 0);
    do_start();
    check_out();
    pps_hold("ov_sync", 0, 30, 2, 0);
    push("ov_done", 0, 30, 2, 1, 1, 0);
    pps_rise();
    check_out();
    push("ov_busy_drop", 0, 30, 2, 0, 0, 0);
    cyc(1);
    check_out();
    push("ov_man", 5, 12, 3, 0, 0, 0);
    cyc(1);
    check_out();
    pps_fall();
    check_int("ov_done_count", done_cnt, 2);

    lvl_start = 5'd0;
    lvl_stop = 5'd31;
    lvl_step = 5'd8;
    wid_start = 4'd1;
    wid_stop = 4'd1;
    dwell = 8'd1;
    sweep_rate = 3'd4;
    push("ab_arm", 1, 0, 4, 1, 0, 0);
    do_start();
    check_out();
    pps_hold("ab_sync", 1, 0, 4, 0);
    pps_hold("ab_adv", 1, 8, 4, 1);
    one_pps = 1'b1;
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    push("ab_stop", 1, 8, 4, 0, 0, 1);
    check_out();
    push("ab_man", 5, 12, 3, 0, 0, 1);
    cyc(1);
    check_out();
    pps_fall();
    check_int("ab_done_count", done_cnt, 2);

    lvl_start = 5'd4;
    lvl_stop = 5'd10;
    lvl_step = 5'd3;
    wid_start = 4'd2;
    wid_stop = 4'd3;
    dwell = 8'd1;
    sweep_rate = 3'd5;
    push("rs_arm", 2, 4, 5, 1, 0, 0);
    do_start();
    check_out();
    pps_hold("rs_sync", 2, 4, 5, 0);
    pps_hold("rs_p1", 2, 7, 5, 1);
    pps_hold("rs_p2", 2, 10, 5, 2);
    pps_hold("rs_p3", 3, 4, 5, 3);
    rst = 1'b1;
    push("rs_reset", 0, 0, 0, 0, 0, 0);
    cyc(1);
    check_out();
    rst = 1'b0;
    push("rs_man", 5, 12, 3, 0, 0, 0);
    cyc(1);
    check_out();
    push("rs_rearm", 2, 4, 5, 1, 0, 0);
    do_start();
    check_out();
    pps_hold("rs_sync2", 2, 4, 5, 0);
    pps_hold("rs_adv2", 2, 7, 5, 1);
    check_int("rs_done_count", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_sweep_seq.md
# flash_sweep_seq

Sequencer directly upstream of the LED flasher stage. It drives that stage's `width`, `level` and `rate` inputs, either passing host-programmed manual values straight through or stepping a 2-D sweep. The sweep runs level (inner loop) × width (outer loop), and each point dwells for a programmable number of 1PPS seconds. It lets a calibration run cover the whole flash amplitude/width space without host intervention per point.

## Interface
- No parameters; all widths are fixed to match the flasher stage.
- `clk` in 1: system clock, 100 MHz; all logic is on this edge.
- `rst` in 1: synchronous reset, active-high.
- `one_pps` in 1: 1PPS, asynchronous to `clk`.
- `start` in 1: one-cycle pulse that begins a sweep.
- `abort` in 1: one-cycle pulse that terminates a sweep.
- `man_width` in 4, `man_level` in 5, `man_rate` in 3: manual values, used when idle.
- `lvl_start` in 5, `lvl_stop` in 5, `lvl_step` in 5: level loop bounds and increment.
- `wid_start` in 4, `wid_stop` in 4: width loop bounds; the width increment is always 1.
- `dwell` in 8: PPS edges per point.
- `sweep_rate` in 3: rate code applied during a sweep.
- `width` out 4, `level` out 5, `rate` out 3: registered outputs to the flasher.
- `busy` out 1: high while a sweep is active.
- `done` out 1: one-cycle pulse on normal sweep completion.
- `point_idx` out 10: index of the current sweep point, starting at 0.

## Operation
- **PPS handling:** `one_pps` passes through a 2-flop synchronizer, then a rising-edge detector produces `pps_tick`, one cycle wide.
- **States:** IDLE, ARM, DWELL, DONE.
- **IDLE:**
  - `width`/`level`/`rate` ← `man_*`, registered with 1-cycle latency.
  - `busy`=0.
  - `start` → ARM.
- **Entering ARM:**
  - All sweep config is latched. Host changes during a sweep are ignored.
  - Degenerate values are normalised at latch: `lvl_step`=0 → 1; `dwell`=0 → 1; `lvl_stop`<`lvl_start` → stop=start; `wid_stop`<`wid_start` → stop=start.
  - Outputs ← (`wid_start`, `lvl_start`, `sweep_rate`); `point_idx`←0; `busy`=1; dwell counter←0.
- **ARM:** the first `pps_tick` → DWELL. This aligns point 0 to a second boundary and does not count toward dwell.
- **DWELL:** each `pps_tick` increments the dwell counter. When the counter reaches the latched `dwell`, the counter ← 0 and the sweep advances:
  - Level advance: compute next level = level + step in 6 bits. If it is ≤ stop, level ← next level.
  - Otherwise level ← start, and if width < wid_stop, width ← width+1.
  - Otherwise (level past stop and width = wid_stop): → DONE, with no output change.
  - On every advance that does not go to DONE, `point_idx` increments.
- **DONE:**
  - Lasts 1 cycle: `done`=1, then → IDLE.
  - `busy` drops on entry to IDLE, and the outputs revert to `man_*` the following cycle.
- **`abort`:**
  - From ARM or DWELL, `abort` → IDLE next cycle, with no `done` pulse.
  - `abort` has priority over a `pps_tick` in the same cycle.
- **`start`:** ignored unless in IDLE. `start` and `abort` together in IDLE → `start` wins (abort is meaningless in IDLE).
- **Reset values:** `width`=0, `level`=0, `rate`=0, `busy`=0, `done`=0, `point_idx`=0; state=IDLE; synchronizer flops=0.

## Timing
- **PPS latency:** `one_pps` rising edge (meeting setup) → `pps_tick` 3 cycles later.
- **Advance latency:** the advancing `pps_tick` → new `width`/`level`/`point_idx` on the next cycle.
- **Start latency:** `start` → sweep outputs and `busy`=1 on the next cycle.
- **Last point:** `done` is asserted the cycle after the final dwell-completing `pps_tick`; `busy`=0 the cycle after that.
- **Point count:** total points = ceil-span(level)×(wid_stop−wid_start+1). The maximum is 512, so `point_idx` ≤ 511 and 10 bits never wrap.
- **Outputs:** all outputs are registered with no combinational paths from inputs. Outputs stay stable across each dwell, so the downstream hs_clk-domain flasher sees quasi-static values.
- **Reset mid-sweep:** the next cycle shows reset values; no `done` pulse.

## Test plan
- **Manual passthrough.** Stimulus: after reset, `man_width`=5, `man_level`=12, `man_rate`=3. Required: 0/0/0 in the first cycle after reset deasserts, then 5/12/3.
- **Sweep order.** Stimulus: `lvl_start`=4, `lvl_stop`=10, `lvl_step`=3, `wid_start`=2, `wid_stop`=3, `dwell`=2. Required: points (w,l) = (2,4),(2,7),(2,10),(3,4),(3,7),(3,10), each held for 2 PPS after the arming PPS. `point_idx` runs 0..5. `done` pulses once, after the 13th PPS edge counting the arming edge.
- **Level-step overflow.** Stimulus: `lvl_start`=30, `lvl_stop`=31, `lvl_step`=31, `wid_start`=`wid_stop`=0, `dwell`=0. Required: a single point (0,30), with no 5-bit wrap to a low level. `done` follows 1 PPS after arming.
- **Abort.** Stimulus: `abort` during DWELL in the same cycle as a `pps_tick`. Required: no advance; `busy`=0 next cycle; no `done`; outputs then = `man_*`.
- **Config latching.** Stimulus: change `lvl_stop` and `sweep_rate` mid-sweep. Required: no effect on the sweep. A second `start` while `busy` is ignored, and `point_idx` is unchanged.
- **Reset mid-sweep.** Stimulus: assert `rst` at `point_idx`=3. Required: all outputs 0 the next cycle; then a fresh `start` re-arms from `point_idx`=0.
